// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings for the fetch stage: next-PC select codes, sequencer states
// and the branch-offset helper.
package fetch_ctrl_pkg;

  localparam logic [2:0] NPC_PC4 = 3'd0;
  localparam logic [2:0] NPC_BEQ = 3'd1;
  localparam logic [2:0] NPC_J   = 3'd2;
  localparam logic [2:0] NPC_JR  = 3'd3;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DROP  = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl_npc_calc.sv
// Combinational next-PC select for the instruction leaving F; zero latency,
// no flow control of its own.
module npc_calc
  import fetch_ctrl_pkg::*;
(
  input  logic [31:0] f_pc,
  input  logic [31:0] d_pc,
  input  logic [25:0] imm26,
  input  logic [31:0] ra,
  input  logic        b_jump,
  input  logic [2:0]  npc_op,
  output logic [31:0] npc
);

  always_comb begin
    npc = f_pc + 32'd4;
    case (npc_op)
      NPC_BEQ: if (b_jump) npc = d_pc + 32'd4 + br_offset(imm26[15:0]);
      NPC_J:   npc = {d_pc[31:28], imm26, 2'b00};
      NPC_JR:  npc = ra;
      default: npc = f_pc + 32'd4;
    endcase
  end

endmodule

// File: rtl/fetch_ctrl.sv
// F-stage PC owner and single-outstanding imem sequencer; instruction passes through
// in the ack cycle, is buffered while stalled, and flushes drain any in-flight request.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [2:0]  npc_op,
  input  logic        b_jump,
  input  logic [25:0] imm26,
  input  logic [31:0] ra,
  input  logic [31:0] d_pc,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic [31:0] f_pc,
  output logic [31:0] f_instr,
  output logic        f_valid,
  output logic        f_adel,
  output logic        fetch_wait,
  output logic [31:0] pc8
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_q, hold_d;
  logic [31:0]  tgt_q, tgt_d;
  logic [31:0]  npc;
  logic         flush;
  logic [31:0]  flush_tgt;
  logic         misal;

  npc_calc u_npc_calc (
    .f_pc   (pc_q),
    .d_pc   (d_pc),
    .imm26  (imm26),
    .ra     (ra),
    .b_jump (b_jump),
    .npc_op (npc_op),
    .npc    (npc)
  );

  assign flush     = exc_req | eret_req;
  assign flush_tgt = exc_req ? EXC_VECTOR : epc;
  assign misal     = (pc_q[1:0] != 2'b00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      hold_q  <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    tgt_d   = tgt_q;
    im_req  = 1'b0;
    f_valid = 1'b0;
    f_instr = '0;
    f_adel  = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_FETCH;

      ST_FETCH: begin
        if (misal) begin
          // Misaligned PC: offer an address-error slot without touching the bus.
          f_valid = ~flush;
          f_adel  = ~flush;
          if (flush)       pc_d = flush_tgt;
          else if (!stall) pc_d = npc;
        end else begin
          im_req = 1'b1;
          if (im_ack) begin
            f_instr = im_rdata;
            f_valid = ~flush;
            if (flush) begin
              pc_d = flush_tgt;
            end else if (stall) begin
              hold_d  = im_rdata;
              state_d = ST_HOLD;
            end else begin
              pc_d = npc;
            end
          end else if (flush) begin
            // The bus cannot cancel, so wait out the ack before redirecting.
            tgt_d   = flush_tgt;
            state_d = ST_DROP;
          end
        end
      end

      ST_HOLD: begin
        f_instr = hold_q;
        f_valid = ~flush;
        if (flush) begin
          pc_d    = flush_tgt;
          state_d = ST_FETCH;
        end else if (!stall) begin
          pc_d    = npc;
          state_d = ST_FETCH;
        end
      end

      ST_DROP: begin
        im_req = 1'b1;
        if (flush) tgt_d = flush_tgt;
        if (im_ack) begin
          pc_d    = flush ? flush_tgt : tgt_q;
          state_d = ST_FETCH;
        end
      end

      default: state_d = ST_BOOT;
    endcase
  end

  assign im_addr    = pc_q;
  assign f_pc       = pc_q;
  assign pc8        = pc_q + 32'd8;
  assign fetch_wait = ~f_valid;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl against a slot-level reference model, with
// a variable-latency memory responder and a short directed prologue.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_V  = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, b_jump, exc_req, eret_req, im_ack;
  logic [2:0]  npc_op;
  logic [25:0] imm26;
  logic [31:0] ra, d_pc, epc, im_rdata;
  logic        im_req, f_valid, f_adel, fetch_wait;
  logic [31:0] im_addr, f_pc, f_instr, pc8;

  fetch_ctrl #(.RESET_PC(RST_PC), .EXC_VECTOR(EXC_V)) dut (
    .clk(clk), .reset(reset), .stall(stall), .npc_op(npc_op), .b_jump(b_jump),
    .imm26(imm26), .ra(ra), .d_pc(d_pc), .exc_req(exc_req), .eret_req(eret_req),
    .epc(epc), .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack),
    .im_rdata(im_rdata), .f_pc(f_pc), .f_instr(f_instr), .f_valid(f_valid),
    .f_adel(f_adel), .fetch_wait(fetch_wait), .pc8(pc8)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: which slot F is offering, not how the RTL encodes it.
  logic        m_boot, m_held, m_drain;
  logic [31:0] m_pc, m_hold_dat, m_tgt;

  // Memory responder.
  logic pend;
  int   waitc, cur_lat, lat_fix;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] ref_npc(input logic [2:0] op, input logic bj,
      input logic [25:0] imm, input logic [31:0] rav, input logic [31:0] dpc,
      input logic [31:0] fpc);
    int off;
    off = int'($signed(imm[15:0]));
    case (op)
      3'd1:    return bj ? 32'(int'(dpc) + 4 + 4 * off) : fpc + 32'd4;
      3'd2:    return {dpc[31:28], imm, 2'b00};
      3'd3:    return rav;
      default: return fpc + 32'd4;
    endcase
  endfunction

  task automatic model_reset();
    m_boot = 1'b1; m_held = 1'b0; m_drain = 1'b0;
    m_pc = RST_PC; m_hold_dat = '0; m_tgt = '0;
    pend = 1'b0; waitc = 0; cur_lat = 0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_f_pc", f_pc, RST_PC);
    chk("rst_im_addr", im_addr, RST_PC);
    chk("rst_pc8", pc8, RST_PC + 32'd8);
    chk("rst_im_req", 32'(im_req), 32'd0);
    chk("rst_f_valid", 32'(f_valid), 32'd0);
    chk("rst_f_instr", f_instr, 32'd0);
    chk("rst_f_adel", 32'(f_adel), 32'd0);
    chk("rst_fetch_wait", 32'(fetch_wait), 32'd1);
  endtask

  // One clock: entered and left at posedge+1.
  task automatic step();
    logic        ack, fl, exp_req, exp_valid, exp_adel, have, mis;
    logic [31:0] tgt, exp_instr, dat;
    logic        n_boot, n_held, n_drain;
    logic [31:0] n_pc, n_hold_dat, n_tgt;

    exp_req = !m_boot && !m_held && (m_drain || m_pc[1:0] == 2'b00);
    chk("im_req", 32'(im_req), 32'(exp_req));
    chk("im_addr", im_addr, m_pc);
    chk("f_pc", f_pc, m_pc);
    chk("pc8", pc8, m_pc + 32'd8);

    if (im_req && !pend) begin
      pend = 1'b1; waitc = 0;
      cur_lat = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
    end
    // A stale ack may land in the boot cycle; it must be ignored.
    ack = m_boot ? ($urandom_range(0, 1) == 1) : (pend && waitc == cur_lat);
    im_ack   = ack;
    im_rdata = ack ? mem_word(im_addr) : $urandom;
    #1;

    fl  = exc_req | eret_req;
    tgt = exc_req ? EXC_V : epc;
    n_boot = m_boot; n_held = m_held; n_drain = m_drain;
    n_pc = m_pc; n_hold_dat = m_hold_dat; n_tgt = m_tgt;
    exp_valid = 1'b0; exp_instr = '0; exp_adel = 1'b0;
    mis = (m_pc[1:0] != 2'b00);

    if (m_boot) begin
      n_boot = 1'b0;
    end else if (m_drain) begin
      if (fl) n_tgt = tgt;
      if (ack) begin
        n_pc = fl ? tgt : m_tgt;
        n_drain = 1'b0;
      end
    end else begin
      have = 1'b1; dat = '0;
      if (m_held)   dat = m_hold_dat;
      else if (mis) dat = '0;
      else if (ack) dat = im_rdata;
      else          have = 1'b0;
      if (fl) begin
        if (have) begin
          n_pc = tgt; n_held = 1'b0;
        end else begin
          n_drain = 1'b1; n_tgt = tgt;
        end
      end else if (have) begin
        exp_valid = 1'b1;
        exp_instr = dat;
        exp_adel  = !m_held && mis;
        if (!stall) begin
          n_pc = ref_npc(npc_op, b_jump, imm26, ra, d_pc, m_pc);
          n_held = 1'b0;
        end else if (!m_held && !mis) begin
          n_held = 1'b1; n_hold_dat = dat;
        end
      end
    end

    chk("f_valid", 32'(f_valid), 32'(exp_valid));
    chk("f_adel", 32'(f_adel), 32'(exp_adel));
    chk("fetch_wait", 32'(fetch_wait), 32'(!exp_valid));
    if (exp_valid) chk("f_instr", f_instr, exp_instr);

    @(posedge clk);
    m_boot = n_boot; m_held = n_held; m_drain = n_drain;
    m_pc = n_pc; m_hold_dat = n_hold_dat; m_tgt = n_tgt;
    if (ack) pend = 1'b0;
    else if (pend) waitc++;
    #1;
  endtask

  task automatic rand_inputs();
    stall    = ($urandom_range(0, 3) == 0);
    exc_req  = ($urandom_range(0, 19) == 0);
    eret_req = ($urandom_range(0, 19) == 0);
    npc_op   = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
    b_jump   = $urandom_range(0, 1) == 1;
    imm26    = 26'($urandom);
    d_pc     = $urandom & 32'hFFFF_FFFC;
    ra       = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
    epc      = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
  endtask

  task automatic clear_ctl();
    stall = 1'b0; exc_req = 1'b0; eret_req = 1'b0; npc_op = 3'd0;
    b_jump = 1'b0; imm26 = '0; ra = '0; d_pc = '0; epc = '0;
  endtask

  initial begin
    clear_ctl();
    im_ack = 1'b0; im_rdata = '0;
    reset = 1'b0;
    lat_fix = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals();
    reset = 1'b1;

    // Zero-wait memory: one instruction per cycle from 0x3000.
    step();
    chk("c2_addr", im_addr, 32'h0000_3000);
    chk("c2_pc8", pc8, 32'h0000_3008);
    step();
    chk("c3_addr", im_addr, 32'h0000_3004);
    step();
    chk("c4_addr", im_addr, 32'h0000_3008);

    // Slow ack under stall: buffer, then advance on release.
    lat_fix = 3;
    stall = 1'b1;
    repeat (4) step();
    chk("hold_req", 32'(im_req), 32'd0);
    chk("hold_instr", f_instr, mem_word(32'h0000_3008));
    step();
    chk("hold_instr2", f_instr, mem_word(32'h0000_3008));
    stall = 1'b0;
    step();
    chk("hold_adv", im_addr, 32'h0000_300C);

    // Control transfers.
    lat_fix = 0;
    npc_op = 3'd1; d_pc = 32'h0000_3010; imm26 = 26'h000FFFE; b_jump = 1'b1;
    step();
    chk("beq_taken", im_addr, 32'h0000_300C);
    b_jump = 1'b0;
    step();
    chk("beq_not", im_addr, 32'h0000_3010);
    npc_op = 3'd2; imm26 = 26'h0000C40;
    step();
    chk("j_tgt", im_addr, 32'h0000_3100);
    npc_op = 3'd3; ra = 32'h0000_3002;
    step();
    chk("jr_tgt", im_addr, 32'h0000_3002);
    chk("adel_set", 32'(f_adel), 32'd1);
    chk("adel_instr", f_instr, 32'd0);
    chk("adel_noreq", 32'(im_req), 32'd0);
    ra = 32'h0000_3020;
    step();
    npc_op = 3'd0;

    // Exception one cycle into a 4-cycle request, then eret while draining.
    lat_fix = 3;
    step();
    exc_req = 1'b1;
    step();
    exc_req = 1'b0;
    chk("drop_addr", im_addr, 32'h0000_3020);
    chk("drop_req", 32'(im_req), 32'd1);
    step();
    step();
    chk("exc_vec", im_addr, EXC_V);
    step();
    exc_req = 1'b1;
    step();
    exc_req = 1'b0; eret_req = 1'b1; epc = 32'h0000_3020;
    step();
    eret_req = 1'b0;
    step();
    chk("eret_drop", im_addr, 32'h0000_3020);

    // Both flushes with ack and stall: exception wins, no hold.
    lat_fix = 0;
    stall = 1'b1; exc_req = 1'b1; eret_req = 1'b1;
    step();
    clear_ctl();
    chk("both_tgt", im_addr, EXC_V);
    chk("both_req", 32'(im_req), 32'd1);

    lat_fix = -1;
    repeat (1500) begin
      rand_inputs();
      step();
    end

    // Asynchronous reset in the middle of traffic.
    #3;
    reset = 1'b0;
    #1;
    chk_reset_vals();
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (1000) begin
      rand_inputs();
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
